// File: rtl/audio_scheduler.sv
// Sound-effect / background-music scheduler: chooses between silence, the music ROM
// stream and prioritised one-shot effects, with a one-deep queue for deferred effects.
module audio_scheduler #(
    parameter int unsigned BEAT_MAX = 1200,
    parameter logic [31:0] SIL_TONE = 32'd50000000
) (
    input  logic        clk22,
    input  logic        rst,
    input  logic        music_en,
    input  logic [1:0]  vol_in,
    input  logic [2:0]  sfx_req,
    input  logic [31:0] bgm_toneL,
    input  logic [31:0] bgm_toneR,
    output logic [11:0] ibeat,
    output logic [31:0] toneL,
    output logic [31:0] toneR,
    output logic [1:0]  volume,
    output logic        sfx_active,
    output logic [1:0]  sfx_id
);

    typedef enum logic [1:0] {IDLE, BGM, SFX} state_t;

    // Effect ids double as priorities: a larger id always wins.
    localparam logic [1:0]  ID_JUMP   = 2'd0;
    localparam logic [1:0]  ID_BUMP   = 2'd1;
    localparam logic [1:0]  ID_COIN   = 2'd2;
    localparam logic [1:0]  ID_NONE   = 2'd3;
    localparam logic [11:0] BEAT_LAST = 12'(BEAT_MAX);

    state_t      state_reg, state_next;
    logic [31:0] step_reg, step_next;
    logic [1:0]  cur_reg, cur_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [1:0]  pend_id_reg, pend_id_next;
    logic [11:0] ibeat_next;
    logic [31:0] tone_l_next, tone_r_next;
    logic [1:0]  volume_next;
    logic        sfx_active_next;
    logic [1:0]  sfx_id_next;

    logic        req_any;
    logic [1:0]  req_id;
    logic        merge_valid;
    logic [1:0]  merge_id;

    function automatic logic [31:0] eff_last(input logic [1:0] id);
        case (id)
            ID_JUMP: eff_last = 32'd7;
            ID_BUMP: eff_last = 32'd3;
            default: eff_last = 32'd5;
        endcase
    endfunction

    function automatic logic [31:0] eff_tone(input logic [1:0] id, input logic [31:0] step);
        case (id)
            ID_JUMP: eff_tone = 32'd523 + 32'd66 * step;
            ID_BUMP: eff_tone = 32'd196;
            ID_COIN: eff_tone = (step < 32'd2) ? 32'd988 : 32'd1319;
            default: eff_tone = SIL_TONE;
        endcase
    endfunction

    always_comb begin
        req_any = |sfx_req;
        req_id  = ID_JUMP;
        if (sfx_req[2])
            req_id = ID_COIN;
        else if (sfx_req[1])
            req_id = ID_BUMP;
    end

    // Pending slot as it would look after absorbing this cycle's request.
    always_comb begin
        merge_valid = pend_valid_reg;
        merge_id    = pend_id_reg;
        if (req_any && (!pend_valid_reg || req_id > pend_id_reg)) begin
            merge_valid = 1'b1;
            merge_id    = req_id;
        end
    end

    always_comb begin
        state_next      = state_reg;
        step_next       = step_reg;
        cur_next        = cur_reg;
        pend_valid_next = pend_valid_reg;
        pend_id_next    = pend_id_reg;
        case (state_reg)
            IDLE, BGM: begin
                pend_valid_next = 1'b0;
                if (req_any) begin
                    state_next = SFX;
                    cur_next   = req_id;
                    step_next  = 32'd0;
                end else begin
                    state_next = music_en ? BGM : IDLE;
                end
            end
            SFX: begin
                if (req_any && req_id > cur_reg) begin
                    cur_next  = req_id;
                    step_next = 32'd0;
                end else if (step_reg >= eff_last(cur_reg)) begin
                    pend_valid_next = 1'b0;
                    step_next       = 32'd0;
                    if (merge_valid)
                        cur_next = merge_id;
                    else
                        state_next = music_en ? BGM : IDLE;
                end else begin
                    step_next       = step_reg + 32'd1;
                    pend_valid_next = merge_valid;
                    pend_id_next    = merge_id;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The beat only runs while the music is actually playing; effects freeze it.
    always_comb begin
        ibeat_next = ibeat;
        if (!music_en)
            ibeat_next = 12'd0;
        else if (state_reg == BGM)
            ibeat_next = (ibeat == BEAT_LAST) ? 12'd0 : ibeat + 12'd1;
    end

    always_comb begin
        tone_l_next     = SIL_TONE;
        tone_r_next     = SIL_TONE;
        volume_next     = 2'd0;
        sfx_active_next = 1'b0;
        sfx_id_next     = ID_NONE;
        case (state_next)
            BGM: begin
                tone_l_next = bgm_toneL;
                tone_r_next = bgm_toneR;
                volume_next = vol_in;
            end
            SFX: begin
                tone_l_next     = eff_tone(cur_next, step_next);
                tone_r_next     = eff_tone(cur_next, step_next);
                volume_next     = (vol_in != 2'd0) ? vol_in : 2'b01;
                sfx_active_next = 1'b1;
                sfx_id_next     = cur_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            step_reg       <= 32'd0;
            cur_reg        <= ID_NONE;
            pend_valid_reg <= 1'b0;
            pend_id_reg    <= ID_JUMP;
            ibeat          <= 12'd0;
            toneL          <= SIL_TONE;
            toneR          <= SIL_TONE;
            volume         <= 2'd0;
            sfx_active     <= 1'b0;
            sfx_id         <= ID_NONE;
        end else begin
            state_reg      <= state_next;
            step_reg       <= step_next;
            cur_reg        <= cur_next;
            pend_valid_reg <= pend_valid_next;
            pend_id_reg    <= pend_id_next;
            ibeat          <= ibeat_next;
            toneL          <= tone_l_next;
            toneR          <= tone_r_next;
            volume         <= volume_next;
            sfx_active     <= sfx_active_next;
            sfx_id         <= sfx_id_next;
        end
    end

endmodule

// File: tb/tb_audio_scheduler.sv
// Bench for audio_scheduler: effect-queue model checked every cycle, plus directed
// scenarios with literal expectations for beat wrap, effect tones, priority and reset.
module tb_audio_scheduler;

    localparam int          BEAT_MAX = 1200;
    localparam logic [31:0] SIL      = 32'd50000000;
    localparam int          M_IDLE = 0, M_BGM = 1, M_SFX = 2;

    logic        clk22 = 1'b0;
    logic        rst;
    logic        music_en;
    logic [1:0]  vol_in;
    logic [2:0]  sfx_req;
    logic [31:0] bgm_toneL, bgm_toneR;
    logic [11:0] ibeat;
    logic [31:0] toneL, toneR;
    logic [1:0]  volume;
    logic        sfx_active;
    logic [1:0]  sfx_id;

    int n_vec = 0;
    int n_err = 0;

    audio_scheduler #(.BEAT_MAX(BEAT_MAX), .SIL_TONE(SIL)) dut (
        .clk22(clk22), .rst(rst), .music_en(music_en), .vol_in(vol_in),
        .sfx_req(sfx_req), .bgm_toneL(bgm_toneL), .bgm_toneR(bgm_toneR),
        .ibeat(ibeat), .toneL(toneL), .toneR(toneR), .volume(volume),
        .sfx_active(sfx_active), .sfx_id(sfx_id)
    );

    always #5 clk22 = ~clk22;

    function automatic logic [31:0] rom_l(input int b);
        return 32'd1000 + 32'(b);
    endfunction
    function automatic logic [31:0] rom_r(input int b);
        return 32'd7000 + 32'(3 * b);
    endfunction

    assign bgm_toneL = rom_l(int'(ibeat));
    assign bgm_toneR = rom_r(int'(ibeat));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the playing effect is a queue of tones still to sound; the head is on air.
    int          m_mode, m_ibeat, m_id, m_pend;
    int          m_q[$];
    logic [31:0] e_tone_l, e_tone_r;
    logic [1:0]  e_vol, e_id;
    logic        e_act;

    task automatic start_fx(input int id);
        m_mode = M_SFX;
        m_id   = id;
        m_q.delete();
        if (id == 0) for (int s = 0; s < 8; s++) m_q.push_back(523 + 66 * s);
        else if (id == 1) for (int s = 0; s < 4; s++) m_q.push_back(196);
        else begin
            m_q.push_back(988); m_q.push_back(988);
            for (int s = 0; s < 4; s++) m_q.push_back(1319);
        end
    endtask

    task automatic model_edge();
        int r, old_beat;
        old_beat = m_ibeat;
        r = sfx_req[2] ? 2 : sfx_req[1] ? 1 : sfx_req[0] ? 0 : -1;
        if (!music_en) m_ibeat = 0;
        else if (m_mode == M_BGM) m_ibeat = (m_ibeat == BEAT_MAX) ? 0 : m_ibeat + 1;
        if (m_mode != M_SFX) begin
            m_pend = -1;
            if (r >= 0) start_fx(r);
            else m_mode = music_en ? M_BGM : M_IDLE;
        end else if (r > m_id) begin
            start_fx(r);
        end else begin
            if (r > m_pend) m_pend = r;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                if (m_pend >= 0) begin
                    start_fx(m_pend);
                    m_pend = -1;
                end else begin
                    m_mode = music_en ? M_BGM : M_IDLE;
                end
            end
        end
        e_tone_l = SIL; e_tone_r = SIL; e_vol = 2'd0; e_act = 1'b0; e_id = 2'd3;
        if (m_mode == M_BGM) begin
            e_tone_l = rom_l(old_beat);
            e_tone_r = rom_r(old_beat);
            e_vol    = vol_in;
        end else if (m_mode == M_SFX) begin
            e_tone_l = 32'(m_q[0]);
            e_tone_r = 32'(m_q[0]);
            e_vol    = (vol_in != 2'd0) ? vol_in : 2'd1;
            e_act    = 1'b1;
            e_id     = 2'(m_id);
        end
    endtask

    always @(posedge clk22 or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_ibeat = 0; m_id = 3; m_pend = -1; m_q.delete();
            e_tone_l = SIL; e_tone_r = SIL; e_vol = 2'd0; e_act = 1'b0; e_id = 2'd3;
        end else begin
            model_edge();
        end
    end

    always @(negedge clk22) begin
        if (rst === 1'b0) begin
            check("cyc_ibeat", 32'(ibeat), 32'(m_ibeat));
            check("cyc_toneL", toneL, e_tone_l);
            check("cyc_toneR", toneR, e_tone_r);
            check("cyc_volume", 32'(volume), 32'(e_vol));
            check("cyc_sfx_active", 32'(sfx_active), 32'(e_act));
            check("cyc_sfx_id", 32'(sfx_id), 32'(e_id));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk22);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; music_en = 1'b0; vol_in = 2'd0; sfx_req = 3'b000;
        #1 rst = 1'b1;
        #1;
        check("rst_ibeat", 32'(ibeat), 0);
        check("rst_toneL", toneL, SIL);
        check("rst_volume", 32'(volume), 0);
        check("rst_sfx_id", 32'(sfx_id), 3);
        check("rst_sfx_active", 32'(sfx_active), 0);

        // Background music: full beat sweep and wrap.
        music_en = 1'b1; vol_in = 2'd2;
        @(negedge clk22) rst = 1'b0;
        cyc(1201);
        check("beat_max", 32'(ibeat), 1200);
        cyc(1);
        check("beat_wrap", 32'(ibeat), 0);
        check("bgm_volume", 32'(volume), 2);
        check("bgm_lag_toneL", toneL, 32'd2200);

        for (int i = 0; i < 2000 && ibeat != 12'd100; i++) cyc(1);
        check("reach_beat100", 32'(ibeat), 100);

        // Jump from BGM at beat 100.
        sfx_req = 3'b001; cyc(1); sfx_req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            check("jump_tone", toneL, 32'(523 + 66 * i));
            check("jump_ibeat_held", 32'(ibeat), 101);
            cyc(1);
        end
        check("jump_done_active", 32'(sfx_active), 0);
        cyc(1);
        check("bgm_resume_beat", 32'(ibeat), 102);

        // Coin preempts jump at step 3.
        sfx_req = 3'b001; cyc(1); sfx_req = 3'b000;
        cyc(3);
        check("jump_step3_tone", toneL, 32'd721);
        sfx_req = 3'b100; cyc(1); sfx_req = 3'b000;
        check("preempt_id", 32'(sfx_id), 2);
        for (int i = 0; i < 6; i++) begin
            check("coin_tone", toneL, (i < 2) ? 32'd988 : 32'd1319);
            cyc(1);
        end
        check("coin_done_active", 32'(sfx_active), 0);

        // Jump then bump queued behind coin: bump wins the slot.
        sfx_req = 3'b100; cyc(1);
        sfx_req = 3'b001; cyc(1);
        sfx_req = 3'b010; cyc(1);
        sfx_req = 3'b000; cyc(4);
        for (int i = 0; i < 4; i++) begin
            check("pend_bump_id", 32'(sfx_id), 1);
            check("pend_bump_tone", toneL, 32'd196);
            cyc(1);
        end
        check("pend_done_id", 32'(sfx_id), 3);

        // Simultaneous jump+bump from IDLE: only bump plays.
        music_en = 1'b0; cyc(1);
        check("idle_ibeat", 32'(ibeat), 0);
        check("idle_tone", toneL, SIL);
        sfx_req = 3'b011; cyc(1); sfx_req = 3'b000;
        check("simul_id", 32'(sfx_id), 1);
        check("simul_tone", toneR, 32'd196);
        cyc(4);
        check("simul_no_pend", 32'(sfx_active), 0);

        // Muted volume during effect, then reset mid-effect.
        vol_in = 2'd0; sfx_req = 3'b010; cyc(1); sfx_req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            check("mute_sfx_volume", 32'(volume), 1);
            cyc(1);
        end
        check("mute_idle_tone", toneL, SIL);
        check("mute_idle_volume", 32'(volume), 0);
        sfx_req = 3'b010; cyc(1); sfx_req = 3'b000; cyc(1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_active", 32'(sfx_active), 0);
        check("async_rst_tone", toneL, SIL);
        check("async_rst_id", 32'(sfx_id), 3);
        music_en = 1'b1; vol_in = 2'd3;
        @(negedge clk22) rst = 1'b0;
        cyc(1);
        check("post_rst_bgm_tone", toneL, 32'd1000);
        check("post_rst_volume", 32'(volume), 3);

        // Mixed request pattern checked by the model only.
        for (int i = 0; i < 60; i++) begin
            music_en = (i < 35) || (i > 50);
            vol_in   = 2'(i / 9);
            case (i % 9)
                0: sfx_req = 3'b001;
                3: sfx_req = (i % 2 == 1) ? 3'b100 : 3'b010;
                5: sfx_req = 3'b001;
                7: sfx_req = 3'b011;
                default: sfx_req = 3'b000;
            endcase
            cyc(1);
        end
        sfx_req = 3'b000;
        cyc(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
